// File: rtl/rom_burst_reader.sv
// Burst read controller for rom_mem: walks an inclusive, wrapping address range and hands each
// word downstream on valid/ready. Optional running checksum enabled by ROM_BURST_CHECKSUM_EN.
module rom_burst_reader #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
`ifdef ROM_BURST_CHECKSUM_EN
  output logic [DW-1:0] checksum,
`endif
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StHold} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;
  logic          launch, accept, at_last;

  // The cycle that pulses done is already StIdle; a start there must still be ignored.
  assign launch  = (state_q == StIdle) && start && !done_q;
  assign accept  = (state_q == StHold) && out_ready;
  assign at_last = (cur_q == last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      last_q      <= '0;
      rom_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      rom_addr_q  <= rom_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (launch) state_d = StIssue;
      StIssue:   state_d = StCapture;
      StCapture: state_d = StHold;
      StHold:    if (out_ready) state_d = at_last ? StIdle : StIssue;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    cur_d       = cur_q;
    last_d      = last_q;
    rom_addr_d  = rom_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    if (launch) begin
      cur_d      = start_addr;
      last_d     = end_addr;
      rom_addr_d = start_addr;
    end
    if (state_q == StCapture) begin
      out_data_d  = rom_data;
      out_valid_d = 1'b1;
    end
    if (accept) begin
      out_valid_d = 1'b0;
      if (at_last) begin
        done_d = 1'b1;
      end else begin
        cur_d      = cur_q + AW'(1);
        rom_addr_d = cur_q + AW'(1);
      end
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    rom_addr  = rom_addr_q;
    out_data  = out_data_q;
    out_valid = out_valid_q;
    done      = done_q;
  end

`ifdef ROM_BURST_CHECKSUM_EN
  logic [DW-1:0] checksum_q, checksum_d;

  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  always_comb begin
    checksum_d = checksum_q;
    if (launch)      checksum_d = '0;
    else if (accept) checksum_d = checksum_q + out_data_q;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a one-cycle-latency ROM model (mem[i] = 8'hA0 + i).
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic [3:0] start_addr, end_addr, rom_addr;
  logic [7:0] rom_data, out_data;
  logic       out_valid, busy, done;
`ifdef ROM_BURST_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= 8'hA0 + {4'h0, rom_addr};

  rom_burst_reader #(.AW(4), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
`ifdef ROM_BURST_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .done       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one burst and checks every cycle timing point, every word and the done pulse.
  task automatic do_burst(input string tag, input logic [3:0] sa, input logic [3:0] ea,
                          input int words, input int stall, input bit inject_start,
                          input bit start_with_done);
    logic [3:0] addr;
    logic [7:0] sum;
    sum = 8'h00;
    out_ready = 1'b1;
    start = 1'b1; start_addr = sa; end_addr = ea;
    step();
    start = 1'b0;
    check({tag, ":busy_issue"}, busy, 1);
    for (int w = 0; w < words; w++) begin
      addr = sa + w[3:0];
      check({tag, ":rom_addr_issue"}, rom_addr, addr);
      if (stall > 0) out_ready = 1'b0;
      if (inject_start && w == 0) begin
        start = 1'b1; start_addr = 4'h9; end_addr = 4'h9;
      end
      step();
      start = 1'b0;
      check({tag, ":valid_capture"}, out_valid, 0);
      step();
      check({tag, ":valid_hold"}, out_valid, 1);
      check({tag, ":data"}, out_data, 8'hA0 + {4'h0, addr});
      for (int s = 0; s < stall; s++) begin
        step();
        check({tag, ":stall_valid"}, out_valid, 1);
        check({tag, ":stall_data"}, out_data, 8'hA0 + {4'h0, addr});
        check({tag, ":stall_addr"}, rom_addr, addr);
      end
      sum = sum + 8'hA0 + {4'h0, addr};
      out_ready = 1'b1;
      step();
      check({tag, ":valid_after_accept"}, out_valid, 0);
      if (w == words - 1) begin
        check({tag, ":done"}, done, 1);
        check({tag, ":busy_at_done"}, busy, 0);
`ifdef ROM_BURST_CHECKSUM_EN
        check({tag, ":checksum"}, checksum, sum);
`endif
      end else begin
        check({tag, ":no_early_done"}, done, 0);
        check({tag, ":busy_mid"}, busy, 1);
      end
    end
    if (start_with_done) begin
      start = 1'b1; start_addr = 4'h3; end_addr = 4'h3;
    end
    step();
    start = 1'b0;
    check({tag, ":done_one_cycle"}, done, 0);
    check({tag, ":idle_after"}, busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check({tag, ":no_extra_word"}, out_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; start_addr = 4'h0; end_addr = 4'h0;
    step();
    step();
    check("reset:rom_addr", rom_addr, 0);
    check("reset:out_data", out_data, 0);
    check("reset:out_valid", out_valid, 0);
    check("reset:busy", busy, 0);
    check("reset:done", done, 0);
    rst = 1'b0;
    step();

    do_burst("basic", 4'd2, 4'd5, 4, 0, 1'b0, 1'b0);
    do_burst("wrap", 4'd14, 4'd1, 4, 0, 1'b0, 1'b0);
    do_burst("backpressure", 4'd0, 4'd2, 3, 5, 1'b0, 1'b0);
    do_burst("single", 4'd7, 4'd7, 1, 0, 1'b0, 1'b0);
    do_burst("start_busy", 4'd4, 4'd6, 3, 0, 1'b1, 1'b0);
    do_burst("start_w_done", 4'd8, 4'd9, 2, 0, 1'b0, 1'b1);
    do_burst("full", 4'd0, 4'd15, 16, 0, 1'b0, 1'b0);
    do_burst("sum", 4'd0, 4'd3, 4, 0, 1'b0, 1'b0);

    // Reset while holding the second word of a burst.
    out_ready = 1'b0;
    start = 1'b1; start_addr = 4'd0; end_addr = 4'd5;
    step();
    start = 1'b0;
    step();
    step();
    check("rst_mid:first_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    step();
    check("rst_mid:hold_valid", out_valid, 1);
    check("rst_mid:hold_data", out_data, 8'hA1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid:out_valid", out_valid, 0);
    check("rst_mid:busy", busy, 0);
    check("rst_mid:rom_addr", rom_addr, 0);
    check("rst_mid:done", done, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_mid:quiet_valid", out_valid, 0);
      check("rst_mid:quiet_done", done, 0);
    end
    do_burst("after_rst", 4'd10, 4'd12, 3, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
